// File: rtl/tc_psum_ctrl.sv
// Partial-sum buffer sequencer: schedules sparse writes into the 1-D buffer, then
// drains the tile one row per beat, masking never-written elements to zero.
module tc_psum_ctrl #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW_POS-1:0]    in_row,
  input  logic [DW_POS-1:0]    in_col,
  input  logic [DW_DATA-1:0]   in_data,
  input  logic                 in_last,
  output logic                 buf_wr_en,
  output logic [DW_POS-1:0]    buf_row,
  output logic [DW_POS-1:0]    buf_col,
  output logic [DW_DATA-1:0]   buf_wdata,
  output logic                 buf_rd_en,
  input  logic [N*DW_DATA-1:0] buf_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*DW_DATA-1:0] out_data,
  output logic [DW_POS-1:0]    out_row,
  output logic                 out_last,
  output logic                 tile_done,
  input  logic                 clr_err,
  output logic                 err_dup,
  output logic                 err_range
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW_POS:0]   M_W      = (DW_POS+1)'(M);
  localparam logic [DW_POS:0]   N_W      = (DW_POS+1)'(N);
  localparam logic [DW_POS-1:0] LAST_ROW = DW_POS'(M - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                state;
  state_t                state_nx;
  logic [M-1:0][N-1:0]   bitmap;
  logic [DW_POS:0]       rp;
  logic                  accept;
  logic                  in_rng;
  logic                  dup_hit;
  logic                  hs;
  logic                  tile_end;
  logic                  rd_issue_p0;
  logic [RW-1:0]         row_idx;
  logic [CW-1:0]         col_idx;

  function automatic logic [N*DW_DATA-1:0] mask_row(input logic [N*DW_DATA-1:0] d,
                                                    input logic [N-1:0]         m);
    logic [N*DW_DATA-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (m[j]) r[j*DW_DATA +: DW_DATA] = d[j*DW_DATA +: DW_DATA];
    return r;
  endfunction

  assign accept   = in_valid & in_ready;
  assign in_rng   = ({1'b0, in_row} < M_W) && ({1'b0, in_col} < N_W);
  assign row_idx  = in_row[RW-1:0];
  assign col_idx  = in_col[CW-1:0];
  assign dup_hit  = in_rng && bitmap[row_idx][col_idx];
  assign hs       = out_valid & out_ready;
  assign tile_end = hs & out_last;
  assign tile_done = tile_end;

  // One read in flight at most; only issue when the output slot is free or draining now.
  assign rd_issue_p0 = (state == DRAIN) && !buf_rd_en && (rp < M_W) && (!out_valid || out_ready);

  always_comb begin
    state_nx = state;
    if (accept && state != DRAIN) state_nx = in_last ? DRAIN : FILL;
    if (tile_end) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      bitmap    <= '0;
      rp        <= '0;
      buf_wr_en <= 1'b0;
      buf_rd_en <= 1'b0;
      buf_row   <= '0;
      buf_col   <= '0;
      buf_wdata <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      err_dup   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != DRAIN);

      // Fill stage: registered write strobe and position
      buf_wr_en <= accept && in_rng;
      if (accept) begin
        buf_row   <= in_row;
        buf_col   <= in_col;
        buf_wdata <= in_data;
      end

      if (tile_end)
        bitmap <= '0;
      else if (accept && in_rng)
        bitmap[row_idx][col_idx] <= 1'b1;

      // Drain stage p1: read strobe out to the buffer
      buf_rd_en <= rd_issue_p0;
      if (rd_issue_p0) begin
        buf_row <= rp[DW_POS-1:0];
        rp      <= rp + 1'b1;
      end
      if (tile_end) rp <= '0;

      // Drain stage p2: capture the returned row with the written-position mask
      if (buf_rd_en) begin
        out_data  <= mask_row(buf_rdata, bitmap[buf_row[RW-1:0]]);
        out_row   <= buf_row;
        out_last  <= (buf_row == LAST_ROW);
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end

      err_range <= (err_range & ~clr_err) | (accept & ~in_rng);
      err_dup   <= (err_dup & ~clr_err) | (accept & dup_hit);
    end
  end

endmodule

// File: tb/tb_tc_psum_ctrl.sv
// Directed bench for tc_psum_ctrl: fill/drain, backpressure, error flags,
// bitmap clearing between tiles and reset in the middle of a drain.
module tb_tc_psum_ctrl;
  localparam int M  = 16;
  localparam int N  = 16;
  localparam int DW = 8;
  localparam int DP = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DP-1:0]   in_row = '0;
  logic [DP-1:0]   in_col = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic            buf_wr_en;
  logic [DP-1:0]   buf_row;
  logic [DP-1:0]   buf_col;
  logic [DW-1:0]   buf_wdata;
  logic            buf_rd_en;
  logic [N*DW-1:0] buf_rdata;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*DW-1:0] out_data;
  logic [DP-1:0]   out_row;
  logic            out_last;
  logic            tile_done;
  logic            clr_err = 1'b0;
  logic            err_dup;
  logic            err_range;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tc_psum_ctrl #(.M(M), .N(N), .DW_DATA(DW), .DW_POS(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_col(in_col),
    .in_data(in_data), .in_last(in_last),
    .buf_wr_en(buf_wr_en), .buf_row(buf_row), .buf_col(buf_col), .buf_wdata(buf_wdata),
    .buf_rd_en(buf_rd_en), .buf_rdata(buf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .tile_done(tile_done),
    .clr_err(clr_err), .err_dup(err_dup), .err_range(err_range)
  );

  // Buffer model: stored XOR 0xA5 so never-written cells read back as 0xA5.
  bit [7:0] mem [16][16];
  always @(posedge clk)
    if (buf_wr_en && buf_row < 5'd16 && buf_col < 5'd16)
      mem[buf_row[3:0]][buf_col[3:0]] <= buf_wdata ^ 8'hA5;

  always_comb begin
    buf_rdata = '0;
    for (int j = 0; j < N; j++)
      buf_rdata[j*DW +: DW] = buf_row[4] ? 8'hEE : (mem[buf_row[3:0]][j] ^ 8'hA5);
  end

  int rd_cnt = 0, td_cnt = 0, td_bad = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (buf_rd_en) rd_cnt <= rd_cnt + 1;
    if (tile_done) td_cnt <= td_cnt + 1;
    if (tile_done && !(out_valid && out_ready && out_last)) td_bad <= td_bad + 1;
    if (buf_wr_en && buf_rd_en) both_cnt <= both_cnt + 1;
  end

  logic [N*DW-1:0] got_d [16];
  logic [DP-1:0]   got_r [16];
  logic            got_l [16];
  int nrows, first_cyc, last_cyc, hold_bad, stalled, inr_hi;
  bit drain_ok;
  bit beat_ok;

  task automatic send_beat(input int r, input int c, input logic [7:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_row   = r[DP-1:0];
    in_col   = c[DP-1:0];
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    beat_ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect_drain(input int stall_row, input int stall_len);
    logic [N*DW-1:0] hold_d;
    logic [DP-1:0]   hold_r;
    bit done;
    done = 0;
    nrows = 0; first_cyc = -1; last_cyc = -1; hold_bad = 0; stalled = 0; inr_hi = 0;
    hold_d = '0; hold_r = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (in_ready) inr_hi++;
      out_ready = 1'b1;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (int'(out_row) == stall_row && stalled < stall_len) begin
          if (stalled == 0) begin
            hold_d = out_data;
            hold_r = out_row;
          end else if (out_data !== hold_d || out_row !== hold_r) begin
            hold_bad++;
          end
          stalled++;
          out_ready = 1'b0;
        end else begin
          if (nrows < 16) begin
            got_d[nrows] = out_data;
            got_r[nrows] = out_row;
            got_l[nrows] = out_last;
          end
          nrows++;
          last_cyc = cyc;
          if (out_last) done = 1;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain_ok = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, tile_done, err_dup, err_range} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 00000000",
               {in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, tile_done, err_dup, err_range});
    end
    checks++;
    if (out_data !== '0 || out_row !== '0 || buf_row !== '0) begin
      errors++;
      $display("FAIL reset_data: out_data=%h out_row=%0d buf_row=%0d, want all 0", out_data, out_row, buf_row);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_fill_drain();
    logic [N*DW-1:0] exp;
    int rd0, td0;
    rd0 = rd_cnt; td0 = td_cnt;
    send_beat(0, 0, 8'h11, 1'b0);
    checks++;
    if (!beat_ok || buf_wr_en !== 1'b1 || buf_row !== 5'd0 || buf_col !== 5'd0 || buf_wdata !== 8'h11) begin
      errors++;
      $display("FAIL t1_wr0: en=%b row=%0d col=%0d data=%h, want 1 0 0 11", buf_wr_en, buf_row, buf_col, buf_wdata);
    end
    send_beat(3, 5, 8'h22, 1'b1);
    checks++;
    if (!beat_ok || buf_wr_en !== 1'b1 || buf_row !== 5'd3 || buf_col !== 5'd5 || buf_wdata !== 8'h22 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_wr1: en=%b row=%0d col=%0d data=%h rdy=%b, want 1 3 5 22 0",
               buf_wr_en, buf_row, buf_col, buf_wdata, in_ready);
    end
    collect_drain(-1, 0);
    checks++;
    if (!drain_ok || nrows != 16) begin
      errors++;
      $display("FAIL t1_rows: done=%0d rows=%0d, want 1 16", drain_ok, nrows);
    end
    checks++;
    if (first_cyc != 2 || last_cyc != 32) begin
      errors++;
      $display("FAIL t1_timing: first=%0d last=%0d, want 2 32", first_cyc, last_cyc);
    end
    for (int r = 0; r < 16; r++) begin
      exp = '0;
      if (r == 0) exp[7:0] = 8'h11;
      if (r == 3) exp[47:40] = 8'h22;
      checks++;
      if (got_d[r] !== exp || got_r[r] !== r[DP-1:0] || got_l[r] !== (r == 15)) begin
        errors++;
        $display("FAIL t1_row%0d: got data=%h row=%0d last=%b, want data=%h row=%0d last=%b",
                 r, got_d[r], got_r[r], got_l[r], exp, r, (r == 15));
      end
    end
    checks++;
    if (td_cnt - td0 != 1 || td_bad != 0 || rd_cnt - rd0 != 16) begin
      errors++;
      $display("FAIL t1_done: tile_done=%0d misplaced=%0d reads=%0d, want 1 0 16", td_cnt - td0, td_bad, rd_cnt - rd0);
    end
    checks++;
    if (in_ready !== 1'b1 || err_dup !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL t1_after: rdy=%b dup=%b rng=%b, want 1 0 0", in_ready, err_dup, err_range);
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] exp;
    int rd0;
    rd0 = rd_cnt;
    send_beat(2, 7, 8'h77, 1'b0);
    send_beat(7, 1, 8'h71, 1'b1);
    collect_drain(2, 5);
    checks++;
    if (!drain_ok || nrows != 16 || stalled != 5 || hold_bad != 0) begin
      errors++;
      $display("FAIL t2_stall: done=%0d rows=%0d stalled=%0d unstable=%0d, want 1 16 5 0", drain_ok, nrows, stalled, hold_bad);
    end
    checks++;
    if (rd_cnt - rd0 != 16) begin
      errors++;
      $display("FAIL t2_reads: got %0d buf_rd_en, want 16", rd_cnt - rd0);
    end
    for (int r = 0; r < 16; r++) begin
      exp = '0;
      if (r == 2) exp[63:56] = 8'h77;
      if (r == 7) exp[15:8] = 8'h71;
      checks++;
      if (got_d[r] !== exp || got_r[r] !== r[DP-1:0]) begin
        errors++;
        $display("FAIL t2_row%0d: got data=%h row=%0d, want data=%h row=%0d", r, got_d[r], got_r[r], exp, r);
      end
    end
  endtask

  task automatic test_errors();
    logic [N*DW-1:0] exp;
    send_beat(16, 0, 8'h5A, 1'b0);
    checks++;
    if (buf_wr_en !== 1'b0 || err_range !== 1'b1 || err_dup !== 1'b0) begin
      errors++;
      $display("FAIL t3_range: wr=%b rng=%b dup=%b, want 0 1 0", buf_wr_en, err_range, err_dup);
    end
    send_beat(2, 2, 8'h33, 1'b0);
    checks++;
    if (buf_wr_en !== 1'b1 || err_dup !== 1'b0) begin
      errors++;
      $display("FAIL t3_first: wr=%b dup=%b, want 1 0", buf_wr_en, err_dup);
    end
    send_beat(2, 2, 8'h44, 1'b1);
    checks++;
    if (buf_wr_en !== 1'b1 || buf_wdata !== 8'h44 || err_dup !== 1'b1 || err_range !== 1'b1) begin
      errors++;
      $display("FAIL t3_dup: wr=%b data=%h dup=%b rng=%b, want 1 44 1 1", buf_wr_en, buf_wdata, err_dup, err_range);
    end
    collect_drain(-1, 0);
    exp = '0;
    exp[23:16] = 8'h44;
    checks++;
    if (!drain_ok || got_d[2] !== exp || got_d[0] !== '0) begin
      errors++;
      $display("FAIL t3_data: done=%0d row2=%h row0=%h, want 1 %h 0", drain_ok, got_d[2], got_d[0], exp);
    end
    checks++;
    if (err_dup !== 1'b1 || err_range !== 1'b1) begin
      errors++;
      $display("FAIL t3_sticky: dup=%b rng=%b, want 1 1", err_dup, err_range);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (err_dup !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL t3_clear: dup=%b rng=%b, want 0 0", err_dup, err_range);
    end
  endtask

  task automatic test_second_tile();
    logic [N*DW-1:0] exp;
    int td0;
    td0 = td_cnt;
    send_beat(1, 1, 8'h55, 1'b1);
    collect_drain(-1, 0);
    checks++;
    if (!drain_ok || nrows != 16 || inr_hi != 0 || td_cnt - td0 != 1) begin
      errors++;
      $display("FAIL t4_drain: done=%0d rows=%0d ready_high=%0d tile_done=%0d, want 1 16 0 1", drain_ok, nrows, inr_hi, td_cnt - td0);
    end
    for (int r = 0; r < 16; r++) begin
      exp = '0;
      if (r == 1) exp[15:8] = 8'h55;
      checks++;
      if (got_d[r] !== exp) begin
        errors++;
        $display("FAIL t4_row%0d: got %h, want %h", r, got_d[r], exp);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [N*DW-1:0] exp;
    int n;
    send_beat(7, 7, 8'h99, 1'b1);
    n = 0;
    while (!(out_valid && out_row == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(out_valid && out_row == 5'd7)) begin
      errors++;
      $display("FAIL t5_reach: out_valid=%b out_row=%0d, want 1 7", out_valid, out_row);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, tile_done, err_dup, err_range} !== 8'h00 ||
        out_data !== '0 || out_row !== '0) begin
      errors++;
      $display("FAIL t5_async: ctrl=%b out_data=%h out_row=%0d, want all 0",
               {in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, tile_done, err_dup, err_range}, out_data, out_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    send_beat(0, 3, 8'h3C, 1'b1);
    collect_drain(-1, 0);
    exp = '0;
    exp[31:24] = 8'h3C;
    checks++;
    if (!drain_ok || nrows != 16 || got_r[0] !== 5'd0 || got_d[0] !== exp || got_d[7] !== '0) begin
      errors++;
      $display("FAIL t5_next: done=%0d rows=%0d row0idx=%0d row0=%h row7=%h, want 1 16 0 %h 0",
               drain_ok, nrows, got_r[0], got_d[0], got_d[7], exp);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_errors();
    test_second_tile();
    test_reset_mid_drain();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL wr_rd_overlap: got %0d cycles with both strobes, want 0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
